index_buff_wr_ctrl: RTL and testbench

INDEX_BUFF_WR_CTRL -- requirements
Module: index_buff_wr_ctrl

---
 rtl/index_buff_wr_ctrl_if.sv | 35 +++
 rtl/index_buff_wr_ctrl.sv | 128 ++++++++++++
 tb/tb_index_buff_wr_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/index_buff_wr_ctrl_if.sv
// Bus bundle for the index buffer write controller.
// Master side: configuration, command and FIFO data.
// Slave side: BRAM write port and status.
interface index_buff_wr_ctrl_if #(
    parameter int unsigned RAM_ROW = 16,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DATA_W  = 64
);
    localparam int unsigned RW = $clog2(RAM_ROW);

    logic                        start;
    logic                        abort;
    logic [ADDR_W:0]             cfg_words;
    logic [RW:0]                 cfg_rows;
    logic [RW-1:0]               cfg_row_base;
    logic                        valid;
    logic [DATA_W-1:0]           datain;
    logic                        ready;
    logic [DATA_W-1:0]           dataout;
    logic [RAM_ROW*ADDR_W-1:0]   addrout_row;
    logic [RAM_ROW-1:0]          wea_row;
    logic                        busy;
    logic                        finished;
    logic                        err;

    modport master (
        output start, abort, cfg_words, cfg_rows, cfg_row_base, valid, datain,
        input  ready, dataout, addrout_row, wea_row, busy, finished, err
    );

    modport slave (
        input  start, abort, cfg_words, cfg_rows, cfg_row_base, valid, datain,
        output ready, dataout, addrout_row, wea_row, busy, finished, err
    );
endinterface

// File: rtl/index_buff_wr_ctrl.sv
// Index buffer write controller: streams FIFO words into a bank of per-row BRAMs,
// filling cfg_rows rows of cfg_words words each, starting at cfg_row_base and
// wrapping past the last row. Write port outputs are combinational (zero latency).
module index_buff_wr_ctrl #(
    parameter int unsigned RAM_ROW = 16,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DATA_W  = 64
) (
    input logic                 clk,
    input logic                 rst,
    index_buff_wr_ctrl_if.slave bus
);
    localparam int unsigned RW = $clog2(RAM_ROW);
    localparam logic [RW:0]   RowsMax = (RW + 1)'(RAM_ROW);
    localparam logic [RW-1:0] LastRow = RW'(RAM_ROW - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e          state_q, state_d;
    logic [ADDR_W:0] words_q, words_d;
    logic [RW:0]     rows_q, rows_d;
    logic [ADDR_W:0] col_cnt_q, col_cnt_d;
    logic [RW:0]     rows_done_q, rows_done_d;
    logic [RW-1:0]   cur_row_q, cur_row_d;
    logic            err_q, err_d;

    logic cfg_illegal;
    logic xfer;
    logic row_end;

    // Row base is widened so the range check also holds for non-power-of-two row counts.
    assign cfg_illegal = (bus.cfg_words == '0) || (bus.cfg_rows == '0) ||
                         (bus.cfg_rows > RowsMax) || ({1'b0, bus.cfg_row_base} >= RowsMax);
    assign xfer        = (state_q == StWrite) && !bus.abort && bus.valid;
    assign row_end     = (col_cnt_q == words_q - 1'b1);

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            words_q     <= '0;
            rows_q      <= '0;
            col_cnt_q   <= '0;
            rows_done_q <= '0;
            cur_row_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            rows_q      <= rows_d;
            col_cnt_q   <= col_cnt_d;
            rows_done_q <= rows_done_d;
            cur_row_q   <= cur_row_d;
            err_q       <= err_d;
        end
    end

    // Next-state: command decode, transfer counting and row advance
    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        rows_d      = rows_q;
        col_cnt_d   = col_cnt_q;
        rows_done_d = rows_done_q;
        cur_row_d   = cur_row_q;
        err_d       = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (cfg_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        words_d     = bus.cfg_words;
                        rows_d      = bus.cfg_rows;
                        cur_row_d   = bus.cfg_row_base;
                        col_cnt_d   = '0;
                        rows_done_d = '0;
                        state_d     = StWrite;
                    end
                end
            end
            StWrite: begin
                if (bus.abort) begin
                    col_cnt_d   = '0;
                    rows_done_d = '0;
                    state_d     = StIdle;
                end else if (xfer) begin
                    if (row_end) begin
                        col_cnt_d   = '0;
                        rows_done_d = rows_done_q + 1'b1;
                        cur_row_d   = (cur_row_q == LastRow) ? '0 : cur_row_q + 1'b1;
                        if (rows_done_q + 1'b1 == rows_q) begin
                            state_d = StDone;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Write port: only the current row's enable and address slice are ever non-zero
    always_comb begin
        bus.wea_row     = '0;
        bus.addrout_row = '0;
        bus.dataout     = '0;
        if (xfer) begin
            bus.wea_row[cur_row_q]                       = 1'b1;
            bus.addrout_row[cur_row_q*ADDR_W +: ADDR_W] = col_cnt_q[ADDR_W-1:0];
            bus.dataout                                  = bus.datain;
        end
    end

    // Status outputs
    always_comb begin
        bus.ready    = (state_q == StWrite) && !bus.abort;
        bus.busy     = (state_q == StWrite) || (state_q == StDone);
        bus.finished = (state_q == StDone);
        bus.err      = err_q;
    end
endmodule

// File: tb/tb_index_buff_wr_ctrl.sv
// Directed bench for index_buff_wr_ctrl: full fill, wrapped fill, valid gaps,
// abort, illegal configurations and asynchronous reset mid-fill.
module tb_index_buff_wr_ctrl;
    localparam int unsigned RAM_ROW = 16;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = 64;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    index_buff_wr_ctrl_if #(.RAM_ROW(RAM_ROW), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    index_buff_wr_ctrl #(.RAM_ROW(RAM_ROW), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] addr_vec(input int row, input int addr);
        logic [255:0] v;
        v = 256'(addr);
        return v << (row * ADDR_W);
    endfunction

    function automatic logic [255:0] onehot(input int row);
        logic [255:0] v;
        v = 256'(1);
        return v << row;
    endfunction

    function automatic logic [63:0] pat(input int i);
        return {32'hA5A5_0000 | 32'(i), 32'(i) ^ 32'h1234_5678};
    endfunction

    // Start a fill and feed valid every cycle, checking every transfer and the finish pulse.
    task automatic run_fill(input int words, input int rows, input int base);
        int n;
        int row;
        n = words * rows;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.cfg_words    = (ADDR_W + 1)'(words);
        bus.cfg_rows     = 5'(rows);
        bus.cfg_row_base = 4'(base);
        bus.valid        = 1'b0;
        #1;
        chk("start_busy", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            row        = (base + i / words) % RAM_ROW;
            bus.datain = pat(i);
            #1;
            chk("fill_wea", bus.wea_row, onehot(row));
            chk("fill_addr", bus.addrout_row, addr_vec(row, i % words));
            chk("fill_data", bus.dataout, pat(i));
            chk("fill_busy", bus.busy, 1);
            chk("fill_fin", bus.finished, 0);
            @(negedge clk);
        end
        bus.valid = 1'b0;
        #1;
        chk("done_fin", bus.finished, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_ready", bus.ready, 0);
        @(negedge clk);
        #1;
        chk("idle_fin", bus.finished, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.cfg_words    = '0;
        bus.cfg_rows     = '0;
        bus.cfg_row_base = '0;
        bus.valid        = 1'b0;
        bus.datain       = '0;
        #1;
        chk("rst_ready", bus.ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wea", bus.wea_row, 0);
        chk("rst_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b1;

        // Full 16-row fill, 4 words per row
        run_fill(4, 16, 0);
        // Wrapped fill: rows 14, 15, 0, 1
        run_fill(3, 4, 14);

        // Valid gaps: 1,0,1,0 with 2 words, 1 row
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_words = 12'd2; bus.cfg_rows = 5'd1; bus.cfg_row_base = 4'd0;
        @(negedge clk);
        bus.start = 1'b0; bus.valid = 1'b1; bus.datain = 64'h11;
        #1;
        chk("gap_wea0", bus.wea_row, onehot(0));
        chk("gap_addr0", bus.addrout_row, addr_vec(0, 0));
        @(negedge clk);
        bus.valid = 1'b0;
        #1;
        chk("gap_idle_wea", bus.wea_row, 0);
        chk("gap_idle_ready", bus.ready, 1);
        chk("gap_idle_data", bus.dataout, 0);
        @(negedge clk);
        bus.valid = 1'b1; bus.datain = 64'h22;
        #1;
        chk("gap_wea1", bus.wea_row, onehot(0));
        chk("gap_addr1", bus.addrout_row, addr_vec(0, 1));
        chk("gap_data1", bus.dataout, 64'h22);
        @(negedge clk);
        bus.valid = 1'b0;
        #1;
        chk("gap_fin", bus.finished, 1);

        // Abort at the 5th word of a 4-word, 2-row fill from row 3
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_words = 12'd4; bus.cfg_rows = 5'd2; bus.cfg_row_base = 4'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("abt_addr", bus.addrout_row, addr_vec(3, i));
            @(negedge clk);
        end
        bus.abort = 1'b1;
        #1;
        chk("abt_wea", bus.wea_row, 0);
        chk("abt_ready", bus.ready, 0);
        chk("abt_data", bus.dataout, 0);
        @(negedge clk);
        bus.abort = 1'b0; bus.valid = 1'b0;
        #1;
        chk("abt_busy", bus.busy, 0);
        chk("abt_fin", bus.finished, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_words = 12'd2; bus.cfg_rows = 5'd1; bus.cfg_row_base = 4'd7;
        #1;
        chk("abt_nofin", bus.finished, 0);
        @(negedge clk);
        bus.start = 1'b0; bus.valid = 1'b1;
        #1;
        chk("abt_new_wea", bus.wea_row, onehot(7));
        chk("abt_new_addr", bus.addrout_row, addr_vec(7, 0));
        @(negedge clk);
        @(negedge clk);
        bus.valid = 1'b0;
        #1;
        chk("abt_new_fin", bus.finished, 1);

        // Illegal configurations
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_words = 12'd0; bus.cfg_rows = 5'd2; bus.cfg_row_base = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("err_w0", bus.err, 1);
        chk("err_w0_busy", bus.busy, 0);
        @(negedge clk);
        #1;
        chk("err_w0_clr", bus.err, 0);
        bus.start = 1'b1; bus.cfg_words = 12'd4; bus.cfg_rows = 5'd17;
        @(negedge clk);
        bus.start = 1'b0; bus.valid = 1'b1;
        #1;
        chk("err_r17", bus.err, 1);
        chk("err_r17_busy", bus.busy, 0);
        chk("err_r17_wea", bus.wea_row, 0);
        @(negedge clk);
        bus.valid = 1'b0;
        #1;
        chk("err_r17_clr", bus.err, 0);

        // Asynchronous reset mid-row
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_words = 12'd4; bus.cfg_rows = 5'd2; bus.cfg_row_base = 4'd5;
        @(negedge clk);
        bus.start = 1'b0; bus.valid = 1'b1; bus.datain = 64'hDEAD;
        @(negedge clk);
        #1;
        chk("ar_pre_wea", bus.wea_row, onehot(5));
        rst = 1'b0;
        #1;
        chk("ar_wea", bus.wea_row, 0);
        chk("ar_addr", bus.addrout_row, 0);
        chk("ar_data", bus.dataout, 0);
        chk("ar_ready", bus.ready, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_fin", bus.finished, 0);
        @(negedge clk);
        bus.valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk("ar_post_busy", bus.busy, 0);
        run_fill(2, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
